// File: rtl/learnt_clause_builder_if.sv
// Handshake and result bus between the var_state array, the learnt clause builder and its consumer.
// The master side drives the start/snapshot/ready inputs; the slave side (the builder) returns status and results.
interface learnt_clause_builder_if #(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
);
  logic                          start_i;
  logic [2*NUM_VARS-1:0]         learnt_lits_i;
  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvls_i;
  logic                          ready_i;
  logic                          busy_o;
  logic                          done_o;
  logic [2*NUM_VARS-1:0]         learnt_clause_o;
  logic [WIDTH_C_LEN-1:0]        lit_cnt_o;
  logic [WIDTH_LVL-1:0]          max_lvl_o;
  logic [WIDTH_LVL-1:0]          bkt_lvl_o;
  logic                          overflow_o;
  logic                          empty_o;

  modport master (
    output start_i, learnt_lits_i, var_lvls_i, ready_i,
    input  busy_o, done_o, learnt_clause_o, lit_cnt_o, max_lvl_o, bkt_lvl_o, overflow_o, empty_o
  );

  modport slave (
    input  start_i, learnt_lits_i, var_lvls_i, ready_i,
    output busy_o, done_o, learnt_clause_o, lit_cnt_o, max_lvl_o, bkt_lvl_o, overflow_o, empty_o
  );
endinterface

// File: rtl/learnt_clause_builder.sv
// Snapshots learnt literals/levels, scans one variable per cycle; done_o rises NUM_VARS+1 cycles after start_i.
// Result is held in DONE until ready_i; start_i is ignored while busy.
module learnt_clause_builder #(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
) (
  input logic                  clk,
  input logic                  rst,
  learnt_clause_builder_if.slave bus
);
  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [2*NUM_VARS-1:0]         snap_lits;
  logic [NUM_VARS*WIDTH_LVL-1:0] snap_lvls;
  logic [IDX_W-1:0]              idx;
  logic [WIDTH_LVL-1:0]          max_q, sec_q, max_nxt, sec_nxt;
  logic [WIDTH_C_LEN-1:0]        cnt_q, cnt_nxt;
  logic                          ovf_q, ovf_nxt;
  logic [1:0]                    cur_lit;
  logic [WIDTH_LVL-1:0]          cur_lvl;
  logic                          last;

  // Result registers are loaded only on the final scan step so they stay stable outside DONE.
  logic [2*NUM_VARS-1:0]         clause_r;
  logic [WIDTH_C_LEN-1:0]        cnt_r;
  logic [WIDTH_LVL-1:0]          max_r, bkt_r;
  logic                          ovf_r, empty_r;

  assign cur_lit = snap_lits[2*idx +: 2];
  assign cur_lvl = snap_lvls[idx*WIDTH_LVL +: WIDTH_LVL];
  assign last    = (idx == IDX_W'(NUM_VARS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = SCAN;
      SCAN:    if (last)        state_nxt = DONE;
      DONE:    if (bus.ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Equal levels fall into the second branch, so a tie at the top leaves second == max.
  always_comb begin
    max_nxt = max_q;
    sec_nxt = sec_q;
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (cur_lit != 2'b00) begin
      if (cur_lvl > max_q) begin
        sec_nxt = max_q;
        max_nxt = cur_lvl;
      end else if (cur_lvl > sec_q) begin
        sec_nxt = cur_lvl;
      end
      if (cnt_q == '1) ovf_nxt = 1'b1;
      else             cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_lits <= '0;
      snap_lvls <= '0;
      idx       <= '0;
      max_q     <= '0;
      sec_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      clause_r  <= '0;
      cnt_r     <= '0;
      max_r     <= '0;
      bkt_r     <= '0;
      ovf_r     <= 1'b0;
      empty_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            snap_lits <= bus.learnt_lits_i;
            snap_lvls <= bus.var_lvls_i;
            idx       <= '0;
            max_q     <= '0;
            sec_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
          end
        end
        SCAN: begin
          idx   <= idx + 1'b1;
          max_q <= max_nxt;
          sec_q <= sec_nxt;
          cnt_q <= cnt_nxt;
          ovf_q <= ovf_nxt;
          if (last) begin
            clause_r <= snap_lits;
            cnt_r    <= cnt_nxt;
            max_r    <= max_nxt;
            bkt_r    <= (cnt_nxt >= WIDTH_C_LEN'(2)) ? sec_nxt : '0;
            ovf_r    <= ovf_nxt;
            empty_r  <= (cnt_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o          = (state != IDLE);
  assign bus.done_o          = (state == DONE);
  assign bus.learnt_clause_o = clause_r;
  assign bus.lit_cnt_o       = cnt_r;
  assign bus.max_lvl_o       = max_r;
  assign bus.bkt_lvl_o       = bkt_r;
  assign bus.overflow_o      = ovf_r;
  assign bus.empty_o         = empty_r;
endmodule
